csr_unit: RTL and testbench
===========================

# csr_unit

Control/status register file and privilege controller at the responding end of the decode stage's CSR and privilege-return outputs. It services csrrw/csrrs reads and writes, and executes mret/sret and trap entry. It tracks the current privilege mode and issues a registered PC redirect to fetch. It sits beside the ID/EX boundary and consumes the decoded csr_op, csr address, priv_ret code and rs1 data for each valid instruction.

## Interface
- MTVEC_RST, 32'h0000_0100, reset value of mtvec
- HART_ID, 0, value returned by mhartid
- clk  in  1  clock, all state updates on rising edge
- rstn  in  1  synchronous active-low reset, sampled on rising edge of clk
- valid  in  1  instruction in stage commits this cycle; low means no state change except mcycle
- csr_op  in  2  00 none, 01 csrrw, 10 csrrs, 11 treated as none
- csr_addr  in  12  CSR address (inst[31:20])
- csr_wdata  in  32  rs1 value
- priv_ret  in  2  00 none, 01 mret, 10 sret, 11 none
- csr_pc  in  32  PC of the committing instruction
- trap_req  in  1  external exception for this instruction
- trap_cause  in  32  mcause value for trap_req
- csr_rdata  out  32  combinational old value of csr_addr; 0 when illegal
- csr_illegal  out  1  combinational: access or return is illegal
- priv_mode  out  2  current privilege: 00 U, 01 S, 11 M
- redirect  out  1  registered one-cycle PC redirect pulse
- redirect_pc  out  32  registered target, valid when redirect=1

## Operation
- Implemented CSRs: mstatus 0x300 (MIE[3], MPIE[7], MPP[12:11], SIE[1], SPIE[5], SPP[8]), mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mcycle 0xB00, mcycleh 0xB80, mhartid 0xF14 (RO); S-mode: sstatus 0x100 (view of SIE/SPIE/SPP), stvec 0x105, sscratch 0x140, sepc 0x141, scause 0x142. Unlisted bits read 0, ignore writes.
- csrrw: new = csr_wdata. csrrs: new = old | csr_wdata; csrrs with csr_wdata==0 performs no write.
- Illegal when: address unimplemented; priv_mode < csr_addr[9:8]; write attempted to csr_addr[11:10]==2'b11; mret when priv_mode!=M; sret when priv_mode==U.
- Commit priority (valid=1): trap_req > csr_illegal (cause 2) > priv_ret > csr_op.
- Trap entry: mepc<=csr_pc; mcause<=cause; MPIE<=MIE; MIE<=0; MPP<=priv_mode; priv<=M; target {mtvec[31:2],2'b00}. No delegation; all traps go to M.
- mret: priv<=MPP; MIE<=MPIE; MPIE<=1; MPP<=U; target mepc. sret: priv<=SPP?S:U; SIE<=SPIE; SPIE<=1; SPP<=U; target sepc.
- Legalization: MPP write of 2'b10 keeps old MPP; mepc/sepc/mtvec/stvec bits[1:0] forced 0 on write.
- mcycle: 64-bit, +1 every cycle; a CSR write to either half loads that half and suppresses the increment that cycle; the other half holds.

## Timing
- Reset (rstn=0 at edge): priv_mode=11, mstatus=0, mtvec=MTVEC_RST, all other CSRs 0, mcycle=0, redirect=0, redirect_pc=0. Reset overrides any commit in the same cycle.
- CSR write visible on csr_rdata the cycle after commit; same-cycle read returns old value (csrrw returns pre-write value).
- redirect asserted exactly one cycle after a committing trap/illegal/mret/sret, for one cycle; never for plain CSR ops.
- Back-to-back commits each produce their own redirect; the later one uses the state updated by the earlier.
- valid=0: inputs ignored, csr_illegal still reflects inputs.

## Configuration
- CSR_SMODE_EN defined: S-mode CSRs, sret and priv_mode=01 supported.
- Undefined: S-mode addresses illegal, sret illegal in all modes, MPP write of 01 keeps old value, SIE/SPIE/SPP read 0.

## Structure
- Package csr_pkg: CSR address constants, csr_op and priv_ret encodings, privilege encodings, cause code CAUSE_ILLEGAL=2, mstatus bit positions.
- Sub-module csr_cycle_counter: 64-bit mcycle with per-half load and increment suppression.

## Test plan
- Reset, then csrrw 0x340 wdata 0xDEAD_BEEF -> rdata 0; next cycle read 0x340 -> 0xDEAD_BEEF, redirect=0.
- trap_req cause 0xB at pc 0x80 in M, mtvec=0x100 -> next cycle redirect=1, redirect_pc=0x100; mepc=0x80, mcause=0xB, MIE=0, MPP=11.
- Set MPP=00, MPIE=1, mepc=0x200, mret -> redirect_pc=0x200, priv_mode=00, MIE=1; then csrrs 0x300 in U -> csr_illegal=1, trap with mcause=2, priv_mode=11.
- mcycle: csrrw 0xB00 wdata 0xFFFF_FFFF -> next cycle low=0xFFFF_FFFF, following cycle low=0, mcycleh incremented by 1.
- csrrw 0xF14 -> illegal trap; csrrs 0xF14 wdata 0 -> rdata=HART_ID, no trap.
- With CSR_SMODE_EN undefined: sret in M -> illegal trap cause 2; read 0x105 -> illegal.

Source files
------------

// File: rtl/csr_pkg.sv
// csr_pkg: shared CSR addresses, encodings and mstatus layout for csr_unit.
package csr_pkg;
  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH  = 12'hB80;
  localparam logic [11:0] CSR_MHARTID  = 12'hF14;
  localparam logic [11:0] CSR_SSTATUS  = 12'h100;
  localparam logic [11:0] CSR_STVEC    = 12'h105;
  localparam logic [11:0] CSR_SSCRATCH = 12'h140;
  localparam logic [11:0] CSR_SEPC     = 12'h141;
  localparam logic [11:0] CSR_SCAUSE   = 12'h142;
  localparam int CYCLE_W = 64;
  localparam logic [31:0] CAUSE_ILLEGAL = 32'd2;
  localparam int MS_SIE  = 1;
  localparam int MS_MIE  = 3;
  localparam int MS_SPIE = 5;
  localparam int MS_MPIE = 7;
  localparam int MS_SPP  = 8;
  localparam int MS_MPP  = 11;
  typedef enum logic [1:0] {OP_NONE = 2'b00, OP_RW = 2'b01, OP_RS = 2'b10, OP_NONE3 = 2'b11} csr_op_e;
  typedef enum logic [1:0] {RET_NONE = 2'b00, RET_MRET = 2'b01, RET_SRET = 2'b10, RET_NONE3 = 2'b11} priv_ret_e;
  typedef enum logic [1:0] {PRIV_U = 2'b00, PRIV_S = 2'b01, PRIV_R = 2'b10, PRIV_M = 2'b11} priv_e;
  function automatic logic [31:0] status_word(input logic mie, input logic mpie, input logic [1:0] mpp,
                                              input logic sie, input logic spie, input logic spp);
    logic [31:0] w;
    w = '0;
    w[MS_MIE] = mie;
    w[MS_MPIE] = mpie;
    w[MS_MPP+:2] = mpp;
    w[MS_SIE] = sie;
    w[MS_SPIE] = spie;
    w[MS_SPP] = spp;
    return w;
  endfunction
endpackage

// File: rtl/csr_unit_cycle_counter.sv
// csr_cycle_counter: 64-bit mcycle; a write to either half loads it and skips that cycle's increment.
module csr_cycle_counter
  import csr_pkg::*;
(
  input  logic               clk,
  input  logic               rstn,
  input  logic               lo_we_i,
  input  logic               hi_we_i,
  input  logic [31:0]        wdata_i,
  output logic [CYCLE_W-1:0] cycle_o
);
  logic [CYCLE_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = lo_we_i ? {cnt_q[63:32], wdata_i} : hi_we_i ? {wdata_i, cnt_q[31:0]} : cnt_q + 64'd1;
  always_ff @(posedge clk)
    if (!rstn) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign cycle_o = cnt_q;
endmodule

// File: rtl/csr_unit.sv
// csr_unit: CSR file, privilege tracking, trap/mret/sret with registered fetch redirect.
// S-mode CSRs, sret and S privilege exist only when CSR_SMODE_EN is defined.
module csr_unit
  import csr_pkg::*;
#(
  parameter logic [31:0] MTVEC_RST = 32'h0000_0100,
  parameter logic [31:0] HART_ID   = 32'd0
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        valid,
  input  logic [1:0]  csr_op,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  input  logic [1:0]  priv_ret,
  input  logic [31:0] csr_pc,
  input  logic        trap_req,
  input  logic [31:0] trap_cause,
  output logic [31:0] csr_rdata,
  output logic        csr_illegal,
  output logic [1:0]  priv_mode,
  output logic        redirect,
  output logic [31:0] redirect_pc
);
`ifdef CSR_SMODE_EN
  localparam bit SMODE = 1'b1;
`else
  localparam bit SMODE = 1'b0;
`endif
  logic [1:0]  priv_q, priv_d, mpp_q, mpp_d;
  logic        mie_q, mie_d, mpie_q, mpie_d, sie_q, sie_d, spie_q, spie_d, spp_q, spp_d;
  logic [31:0] mtvec_q, mtvec_d, mscratch_q, mscratch_d, mepc_q, mepc_d, mcause_q, mcause_d;
  logic [31:0] stvec_q, stvec_d, sscratch_q, sscratch_d, sepc_q, sepc_d, scause_q, scause_d;
  logic        redirect_q, redirect_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic [63:0] mcycle;
  logic        cyc_lo_we, cyc_hi_we;
  logic [31:0] mstatus_rd, sstatus_rd, old_val, new_val;
  logic        hit, is_acc, is_wr, acc_ill, ret_ill, take_trap, do_mret, do_sret, do_wr, mpp_ok;

  csr_cycle_counter u_cycle (
    .clk     (clk),
    .rstn    (rstn),
    .lo_we_i (cyc_lo_we),
    .hi_we_i (cyc_hi_we),
    .wdata_i (new_val),
    .cycle_o (mcycle)
  );

  assign mstatus_rd = status_word(mie_q, mpie_q, mpp_q, sie_q, spie_q, spp_q);
  assign sstatus_rd = status_word(1'b0, 1'b0, 2'b00, sie_q, spie_q, spp_q);

  always_comb begin
    hit = 1'b1;
    old_val = '0;
    case (csr_addr)
      CSR_MSTATUS:  old_val = mstatus_rd;
      CSR_MTVEC:    old_val = mtvec_q;
      CSR_MSCRATCH: old_val = mscratch_q;
      CSR_MEPC:     old_val = mepc_q;
      CSR_MCAUSE:   old_val = mcause_q;
      CSR_MCYCLE:   old_val = mcycle[31:0];
      CSR_MCYCLEH:  old_val = mcycle[63:32];
      CSR_MHARTID:  old_val = HART_ID;
      CSR_SSTATUS:  begin hit = SMODE; old_val = sstatus_rd; end
      CSR_STVEC:    begin hit = SMODE; old_val = stvec_q; end
      CSR_SSCRATCH: begin hit = SMODE; old_val = sscratch_q; end
      CSR_SEPC:     begin hit = SMODE; old_val = sepc_q; end
      CSR_SCAUSE:   begin hit = SMODE; old_val = scause_q; end
      default:      hit = 1'b0;
    endcase
  end

  // csrrs with a zero mask is a pure read, so it may target read-only CSRs.
  assign is_acc = (csr_op == OP_RW) || (csr_op == OP_RS);
  assign is_wr = (csr_op == OP_RW) || ((csr_op == OP_RS) && (csr_wdata != '0));
  assign acc_ill = is_acc && (!hit || (priv_q < csr_addr[9:8]) || (is_wr && csr_addr[11:10] == 2'b11));
  assign ret_ill = ((priv_ret == RET_MRET) && (priv_q != PRIV_M)) ||
                   ((priv_ret == RET_SRET) && (!SMODE || (priv_q == PRIV_U)));
  assign csr_illegal = acc_ill || ret_ill;
  assign csr_rdata = csr_illegal ? '0 : old_val;
  assign new_val = (csr_op == OP_RW) ? csr_wdata : (old_val | csr_wdata);
  assign mpp_ok = (new_val[MS_MPP+:2] == PRIV_M) || (new_val[MS_MPP+:2] == PRIV_U) ||
                  (SMODE && new_val[MS_MPP+:2] == PRIV_S);

  assign take_trap = valid && (trap_req || csr_illegal);
  assign do_mret = valid && !take_trap && (priv_ret == RET_MRET);
  assign do_sret = valid && !take_trap && (priv_ret == RET_SRET);
  assign do_wr = valid && !take_trap && !do_mret && !do_sret && is_wr;

  always_comb begin
    priv_d = priv_q;
    mpp_d = mpp_q;
    mie_d = mie_q;
    mpie_d = mpie_q;
    sie_d = sie_q;
    spie_d = spie_q;
    spp_d = spp_q;
    mtvec_d = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d = mepc_q;
    mcause_d = mcause_q;
    stvec_d = stvec_q;
    sscratch_d = sscratch_q;
    sepc_d = sepc_q;
    scause_d = scause_q;
    redirect_d = 1'b0;
    redirect_pc_d = redirect_pc_q;
    cyc_lo_we = 1'b0;
    cyc_hi_we = 1'b0;
    if (take_trap) begin
      mepc_d = csr_pc;
      mcause_d = trap_req ? trap_cause : CAUSE_ILLEGAL;
      mpie_d = mie_q;
      mie_d = 1'b0;
      mpp_d = priv_q;
      priv_d = PRIV_M;
      redirect_d = 1'b1;
      redirect_pc_d = {mtvec_q[31:2], 2'b00};
    end else if (do_mret) begin
      priv_d = mpp_q;
      mie_d = mpie_q;
      mpie_d = 1'b1;
      mpp_d = PRIV_U;
      redirect_d = 1'b1;
      redirect_pc_d = mepc_q;
    end else if (do_sret) begin
      priv_d = spp_q ? PRIV_S : PRIV_U;
      sie_d = spie_q;
      spie_d = 1'b1;
      spp_d = 1'b0;
      redirect_d = 1'b1;
      redirect_pc_d = sepc_q;
    end else if (do_wr) begin
      case (csr_addr)
        CSR_MSTATUS: begin
          mie_d = new_val[MS_MIE];
          mpie_d = new_val[MS_MPIE];
          mpp_d = mpp_ok ? new_val[MS_MPP+:2] : mpp_q;
          sie_d = SMODE ? new_val[MS_SIE] : sie_q;
          spie_d = SMODE ? new_val[MS_SPIE] : spie_q;
          spp_d = SMODE ? new_val[MS_SPP] : spp_q;
        end
        CSR_SSTATUS: begin
          sie_d = new_val[MS_SIE];
          spie_d = new_val[MS_SPIE];
          spp_d = new_val[MS_SPP];
        end
        CSR_MTVEC:    mtvec_d = {new_val[31:2], 2'b00};
        CSR_MSCRATCH: mscratch_d = new_val;
        CSR_MEPC:     mepc_d = {new_val[31:2], 2'b00};
        CSR_MCAUSE:   mcause_d = new_val;
        CSR_MCYCLE:   cyc_lo_we = 1'b1;
        CSR_MCYCLEH:  cyc_hi_we = 1'b1;
        CSR_STVEC:    stvec_d = {new_val[31:2], 2'b00};
        CSR_SSCRATCH: sscratch_d = new_val;
        CSR_SEPC:     sepc_d = {new_val[31:2], 2'b00};
        CSR_SCAUSE:   scause_d = new_val;
        default:      ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      priv_q <= PRIV_M;
      mpp_q <= 2'b00;
      mie_q <= 1'b0;
      mpie_q <= 1'b0;
      sie_q <= 1'b0;
      spie_q <= 1'b0;
      spp_q <= 1'b0;
      mtvec_q <= MTVEC_RST;
      mscratch_q <= '0;
      mepc_q <= '0;
      mcause_q <= '0;
      stvec_q <= '0;
      sscratch_q <= '0;
      sepc_q <= '0;
      scause_q <= '0;
      redirect_q <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      priv_q <= priv_d;
      mpp_q <= mpp_d;
      mie_q <= mie_d;
      mpie_q <= mpie_d;
      sie_q <= sie_d;
      spie_q <= spie_d;
      spp_q <= spp_d;
      mtvec_q <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q <= mepc_d;
      mcause_q <= mcause_d;
      stvec_q <= stvec_d;
      sscratch_q <= sscratch_d;
      sepc_q <= sepc_d;
      scause_q <= scause_d;
      redirect_q <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  assign priv_mode = priv_q;
  assign redirect = redirect_q;
  assign redirect_pc = redirect_pc_q;
endmodule

// File: tb/tb_csr_unit.sv
// tb_csr_unit: directed vectors for csr_unit; expectations are queued and checked by a separate monitor.
module tb_csr_unit;
  localparam logic [1:0] NONE = 2'b00, RW = 2'b01, RS = 2'b10;
  localparam logic [1:0] MRET = 2'b01, SRET = 2'b10;
  localparam int K_RDATA = 0, K_ILL = 1, K_REDIR = 2, K_RPC = 3, K_PRIV = 4;

  logic        clk = 1'b0, rstn = 1'b0, valid = 1'b0, trap_req = 1'b0;
  logic [1:0]  csr_op = '0, priv_ret = '0;
  logic [11:0] csr_addr = '0;
  logic [31:0] csr_wdata = '0, csr_pc = '0, trap_cause = '0;
  logic [31:0] csr_rdata, redirect_pc;
  logic        csr_illegal, redirect;
  logic [1:0]  priv_mode;

  csr_unit dut (
    .clk(clk), .rstn(rstn), .valid(valid), .csr_op(csr_op), .csr_addr(csr_addr),
    .csr_wdata(csr_wdata), .priv_ret(priv_ret), .csr_pc(csr_pc), .trap_req(trap_req),
    .trap_cause(trap_cause), .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
    .priv_mode(priv_mode), .redirect(redirect), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    int          kind;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t e;
  logic [31:0] act;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      case (e.kind)
        K_RDATA: act = csr_rdata;
        K_ILL:   act = {31'd0, csr_illegal};
        K_REDIR: act = {31'd0, redirect};
        K_RPC:   act = redirect_pc;
        default: act = {30'd0, priv_mode};
      endcase
      checks++;
      if (act !== e.val || e.due != cyc) begin
        errors++;
        $display("FAIL %s (cycle %0d): got %h, expected %h", e.name, cyc, act, e.val);
      end
    end
  end

  task automatic chk(input int off, input int kind, input logic [31:0] v, input string nm);
    sb.push_back('{cyc + off, kind, v, nm});
  endtask

  task automatic step(input logic v, input logic [1:0] op, input logic [11:0] a, input logic [31:0] wd,
                      input logic [1:0] ret, input logic [31:0] pc, input logic tr, input logic [31:0] tc);
    @(posedge clk);
    #1;
    valid = v; csr_op = op; csr_addr = a; csr_wdata = wd;
    priv_ret = ret; csr_pc = pc; trap_req = tr; trap_cause = tc;
  endtask

  task automatic rw(input logic [11:0] a, input logic [31:0] wd); step(1, RW, a, wd, NONE, 0, 0, 0); endtask
  task automatic rs(input logic [11:0] a, input logic [31:0] wd); step(1, RS, a, wd, NONE, 0, 0, 0); endtask
  task automatic ret(input logic [1:0] r); step(1, NONE, 0, 0, r, 0, 0, 0); endtask
  task automatic trap(input logic [31:0] pc, input logic [31:0] c); step(1, NONE, 0, 0, NONE, pc, 1, c); endtask
  task automatic idle(); step(0, NONE, 0, 0, NONE, 0, 0, 0); endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    rw(12'h340, 32'h1234);
    rs(12'h340, 0);
    rstn = 1'b1;
    chk(0, K_RDATA, 32'h0, "reset_overrides_write");
    chk(0, K_PRIV, 32'h3, "reset_priv");
    chk(0, K_REDIR, 32'h0, "reset_redirect");
    chk(0, K_RPC, 32'h0, "reset_redirect_pc");
    rs(12'h305, 0);                 chk(0, K_RDATA, 32'h100, "reset_mtvec");
    rw(12'h340, 32'hDEAD_BEEF);     chk(0, K_RDATA, 32'h0, "csrrw_old_value"); chk(1, K_REDIR, 0, "csrrw_no_redirect");
    rs(12'h340, 0);                 chk(0, K_RDATA, 32'hDEAD_BEEF, "mscratch_written");
    trap(32'h80, 32'hB);            chk(1, K_REDIR, 1, "trap_redirect"); chk(1, K_RPC, 32'h100, "trap_target"); chk(1, K_PRIV, 3, "trap_priv");
    rs(12'h341, 0);                 chk(0, K_RDATA, 32'h80, "trap_mepc");
    rs(12'h342, 0);                 chk(0, K_RDATA, 32'hB, "trap_mcause"); chk(0, K_REDIR, 0, "redirect_one_cycle");
    rs(12'h300, 0);                 chk(0, K_RDATA, 32'h1800, "trap_mstatus");
    rw(12'h300, 32'h88);            chk(0, K_RDATA, 32'h1800, "mstatus_old");
    rs(12'h300, 0);                 chk(0, K_RDATA, 32'h88, "mstatus_written");
    rw(12'h341, 32'h203);           chk(0, K_RDATA, 32'h80, "mepc_old");
    rs(12'h341, 0);                 chk(0, K_RDATA, 32'h200, "mepc_legalized");
    ret(MRET);                      chk(0, K_ILL, 0, "mret_legal"); chk(1, K_REDIR, 1, "mret_redirect");
    chk(1, K_RPC, 32'h200, "mret_target"); chk(1, K_PRIV, 0, "mret_priv_u");
    step(1, RS, 12'h300, 1, NONE, 32'h300, 0, 0);
    chk(0, K_ILL, 1, "u_mstatus_illegal"); chk(0, K_RDATA, 0, "illegal_rdata_zero");
    chk(1, K_REDIR, 1, "illegal_redirect"); chk(1, K_RPC, 32'h100, "illegal_target"); chk(1, K_PRIV, 3, "illegal_priv_m");
    rs(12'h342, 0);                 chk(0, K_RDATA, 32'h2, "illegal_cause");
    rs(12'h300, 0);                 chk(0, K_RDATA, 32'h80, "mret_mie_then_trap");
    rs(12'h341, 0);                 chk(0, K_RDATA, 32'h300, "illegal_mepc");
    rw(12'h300, 32'h1800);
    rw(12'h300, 32'h1000);          chk(0, K_RDATA, 32'h1800, "mpp_set_m");
`ifndef CSR_SMODE_EN
    rw(12'h300, 32'h0800);          chk(0, K_RDATA, 32'h1800, "mpp_10_kept");
`endif
    rs(12'h300, 0);                 chk(0, K_RDATA, 32'h1800, "mpp_final");
    rw(12'hB80, 32'h5);
    rw(12'hB00, 32'hFFFF_FFFF);
    rs(12'hB00, 0);                 chk(0, K_RDATA, 32'hFFFF_FFFF, "mcycle_loaded");
    rs(12'hB80, 0);                 chk(0, K_RDATA, 32'h6, "mcycleh_carry");
    rs(12'hB00, 0);                 chk(0, K_RDATA, 32'h1, "mcycle_counting");
    rw(12'hF14, 32'h1);             chk(0, K_ILL, 1, "mhartid_write_illegal"); chk(1, K_REDIR, 1, "mhartid_trap");
    rs(12'hF14, 0);                 chk(0, K_ILL, 0, "mhartid_read_legal"); chk(0, K_RDATA, 32'h0, "mhartid_value");
    chk(1, K_REDIR, 0, "mhartid_read_no_trap");
`ifndef CSR_SMODE_EN
    ret(SRET);                      chk(0, K_ILL, 1, "sret_illegal"); chk(1, K_REDIR, 1, "sret_trap"); chk(1, K_RPC, 32'h100, "sret_target");
    rs(12'h342, 0);                 chk(0, K_RDATA, 32'h2, "sret_cause");
    rs(12'h105, 0);                 chk(0, K_ILL, 1, "stvec_illegal");
`endif
    step(0, RW, 12'h340, 32'h55, NONE, 0, 1, 7);
    chk(0, K_ILL, 0, "invalid_legal"); chk(1, K_REDIR, 0, "invalid_no_redirect");
    rs(12'h340, 0);                 chk(0, K_RDATA, 32'hDEAD_BEEF, "invalid_no_write");
    trap(32'h400, 32'h5);           chk(1, K_REDIR, 1, "b2b_trap"); chk(1, K_RPC, 32'h100, "b2b_trap_target");
    ret(MRET);                      chk(1, K_REDIR, 1, "b2b_mret"); chk(1, K_RPC, 32'h400, "b2b_mret_target"); chk(1, K_PRIV, 3, "b2b_priv");
    idle();                         chk(1, K_REDIR, 0, "b2b_pulse_end");
    repeat (3) idle();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
